// File: rtl/gate_test_pkg.sv
// gate_test_pkg
//   Shared types and constants for the 2-input gate test sequencer.
//   - state_e   : sequencer FSM states
//   - VEC_ORDER : order in which {a,b} vectors are applied (element i = vector i)
//   - TT_*      : truth tables of common cells, bit index = {a,b}
package gate_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [3:0][1:0] VEC_ORDER = {2'b11, 2'b10, 2'b01, 2'b00};

   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_settle_timer.sv
// gate_settle_timer
//   Load / count-down settle counter. `load` presets the counter so that
//   `expired` is seen in the SETTLE_CYCLES-th cycle after the load edge.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     load       : preset the counter (edge that enters SETTLE)
//     expired    : counter has reached zero
module gate_settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int         W        = $clog2(SETTLE_CYCLES + 1);
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = LOAD_VAL;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Drives all four {a,b} vectors onto a 2-input gate, waits SETTLE_CYCLES
//   per vector, samples y_in and compares it with a latched truth table.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     start        : begin a run (IDLE only)
//     abort        : cancel a run in SETTLE/SAMPLE
//     tt_expected  : expected truth table, bit index = {a,b}
//     y_in         : gate output under test
//     a_out, b_out : gate inputs
//     busy, done   : run in progress / one-cycle completion pulse
//     pass, fail_mask, err_count : results of the last run
module gate_test_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] tt_expected,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [2:0] err_count
);

   import gate_test_pkg::*;

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] exp_q, exp_d;
   logic [3:0] fail_mask_q, fail_mask_d;
   logic [2:0] err_count_q, err_count_d;
   logic       a_q, a_d, b_q, b_d;
   logic       pass_q, pass_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       tmr_load, tmr_expired;
   logic [1:0] vec;
   logic       miss;

   gate_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      exp_d       = exp_q;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      a_d         = a_q;
      b_d         = b_q;
      pass_d      = pass_q;
      tmr_load    = 1'b0;
      vec         = VEC_ORDER[idx_q];
      // Case inequality so an x/z output from the cell is a mismatch.
      miss        = (y_in !== exp_q[vec]);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               exp_d        = tt_expected;
               fail_mask_d  = '0;
               err_count_d  = '0;
               pass_d       = 1'b0;
               idx_d        = '0;
               {a_d, b_d}   = VEC_ORDER[0];
               tmr_load     = 1'b1;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d    = ST_IDLE;
               {a_d, b_d} = 2'b00;
               pass_d     = 1'b0;
               idx_d      = '0;
            end else if (tmr_expired) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            // Abort wins: the sample taken this cycle is discarded.
            if (abort) begin
               state_d    = ST_IDLE;
               {a_d, b_d} = 2'b00;
               pass_d     = 1'b0;
               idx_d      = '0;
            end else begin
               if (miss) begin
                  fail_mask_d[vec] = 1'b1;
                  err_count_d      = err_count_q + 3'd1;
               end
               if (idx_q == 2'd3) begin
                  // pass uses the count including this last sample, so it is
                  // valid together with the done pulse.
                  pass_d  = (err_count_d == 3'd0);
                  state_d = ST_DONE;
               end else begin
                  idx_d      = idx_q + 2'd1;
                  {a_d, b_d} = VEC_ORDER[idx_q + 2'd1];
                  tmr_load   = 1'b1;
                  state_d    = ST_SETTLE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status flags are registered copies of the next-state decode.
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         exp_q       <= '0;
         fail_mask_q <= '0;
         err_count_q <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         pass_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         exp_q       <= exp_d;
         fail_mask_q <= fail_mask_d;
         err_count_q <= err_count_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pass_q      <= pass_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer
//   Two sequencers (SETTLE_CYCLES 2 and 1) each driving a behavioural gate
//   whose truth table, per-vector output flips and high-z mode are set by
//   the bench. Expected results come from the truth-table algebra:
//   mismatches = gate ^ flips ^ expected table.
module tb_gate_test_sequencer;
   import gate_test_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]      start_r, abort_r;
   logic [1:0][3:0] tt_r;
   logic [1:0]      a_w, b_w, busy_w, done_w, pass_w;
   logic [1:0][3:0] fm_w;
   logic [1:0][2:0] ec_w;

   logic [3:0] g0, g1, f0, f1;
   logic       z0, z1;
   wire        y0, y1;

   assign y0 = z0 ? 1'bz : (g0[{a_w[0], b_w[0]}] ^ f0[{a_w[0], b_w[0]}]);
   assign y1 = z1 ? 1'bz : (g1[{a_w[1], b_w[1]}] ^ f1[{a_w[1], b_w[1]}]);

   gate_test_sequencer #(.SETTLE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
      .tt_expected(tt_r[0]), .y_in(y0), .a_out(a_w[0]), .b_out(b_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .fail_mask(fm_w[0]), .err_count(ec_w[0])
   );

   gate_test_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
      .tt_expected(tt_r[1]), .y_in(y1), .a_out(a_w[1]), .b_out(b_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .fail_mask(fm_w[1]), .err_count(ec_w[1])
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_model(input int which, input logic [3:0] g, input logic [3:0] f, input logic z);
      if (which == 0) begin g0 = g; f0 = f; z0 = z; end
      else            begin g1 = g; f1 = f; z1 = z; end
   endtask

   task automatic check_reset(input int w);
      chk("rst_a",    a_w[w],    0);
      chk("rst_b",    b_w[w],    0);
      chk("rst_busy", busy_w[w], 0);
      chk("rst_done", done_w[w], 0);
      chk("rst_pass", pass_w[w], 0);
      chk("rst_fm",   fm_w[w],   0);
      chk("rst_ec",   ec_w[w],   0);
   endtask

   // Full run; called at a negedge, returns at the negedge of the cycle after done.
   task automatic run(input int w, input logic [3:0] tt);
      int sc, n;
      logic [3:0] g, f, efm;
      logic z;
      sc  = (w == 0) ? 2 : 1;
      g   = (w == 0) ? g0 : g1;
      f   = (w == 0) ? f0 : f1;
      z   = (w == 0) ? z0 : z1;
      efm = z ? 4'hF : (g ^ f ^ tt);
      tt_r[w]    = tt;
      start_r[w] = 1'b1;
      @(negedge clk);
      start_r[w] = 1'b0;
      tt_r[w]    = ~tt;            // latched at start; later changes must not matter
      chk("clr_fm",   fm_w[w],   0);
      chk("clr_ec",   ec_w[w],   0);
      chk("clr_pass", pass_w[w], 0);
      chk("busy",     busy_w[w], 1);
      n = 0;
      while (!done_w[w] && n < 200) begin
         chk("vec", {a_w[w], b_w[w]}, n / (sc + 1));
         @(negedge clk);
         n++;
      end
      chk("latency", n, 4 * (sc + 1));
      @(negedge clk);
      chk("done_pulse", done_w[w], 0);
      chk("busy_end",   busy_w[w], 0);
      chk("fail_mask",  fm_w[w],   efm);
      chk("err_count",  ec_w[w],   $countones(efm));
      chk("pass",       pass_w[w], efm == 4'h0);
   endtask

   initial begin
      logic [3:0] gates [5];
      logic [3:0] rg, rf, rt, efm;
      logic       got_done;
      int         w;
      gates = '{TT_NOR, TT_NAND, TT_AND, TT_OR, TT_XOR};
      start_r = '0; abort_r = '0; tt_r = '0;
      set_model(0, TT_NOR, 4'h0, 1'b0);
      set_model(1, TT_NOR, 4'h0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      @(negedge clk);

      // NOR cell, correct and wrong tables
      run(0, TT_NOR);
      run(0, TT_NAND);

      // Floating output: expect all-ones so any non-1 value is a miss
      set_model(0, TT_NOR, 4'h0, 1'b1);
      run(0, 4'b1111);
      set_model(0, TT_NOR, 4'h0, 1'b0);

      // Abort during vector-2 settle, with a start re-pulse while busy
      tt_r[0] = TT_NAND; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         start_r[0] = (n == 2);
         @(negedge clk);
      end
      start_r[0] = 1'b0;
      chk("abort_vec2", {a_w[0], b_w[0]}, 2'b10);
      abort_r[0] = 1'b1;
      @(negedge clk);
      abort_r[0] = 1'b0;
      efm = (TT_NOR ^ TT_NAND) & 4'b0011;
      chk("abort_a",    a_w[0],    0);
      chk("abort_b",    b_w[0],    0);
      chk("abort_busy", busy_w[0], 0);
      chk("abort_done", done_w[0], 0);
      chk("abort_pass", pass_w[0], 0);
      chk("abort_fm",   fm_w[0],   efm);
      chk("abort_ec",   ec_w[0],   $countones(efm));
      got_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         got_done |= done_w[0] | busy_w[0];
      end
      chk("abort_quiet", got_done, 0);

      // Reset during SAMPLE of vector 3
      run(0, TT_NOR);
      tt_r[0] = TT_NAND; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (11) @(negedge clk);
      chk("pre_rst_busy", busy_w[0], 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset(0);
      check_reset(1);
      run(0, TT_NOR);

      // SETTLE_CYCLES=1, back-to-back runs
      set_model(1, TT_XOR, 4'h0, 1'b0);
      run(1, TT_AND);
      run(1, TT_XOR);

      // Randomized cells, flips and expected tables
      for (int i = 0; i < 24; i++) begin
         w  = i % 2;
         rg = gates[$urandom_range(0, 4)];
         rf = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         rt = ($urandom_range(0, 1) == 1) ? rg : 4'($urandom);
         set_model(w, rg, rf, 1'b0);
         run(w, rt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-checking sequencer for one 2-input switch-level gate cell (CMOS NOR, NAND and similar) in the structural-modelling library. It drives all four input vectors onto the gate under test and waits a programmable settle time before sampling each output. Each sample is compared against an expected truth table, and the block reports a pass flag and a per-vector failure mask. It sits between the testbench top and the gate instance, and owns the gate's `a` and `b` inputs for the length of a run.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles the gate output is allowed to settle after each vector is applied; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE.
- `abort`  in  1  cancels a run in progress; ignored in IDLE and DONE.
- `tt_expected`  in  4  expected truth table; bit index = {a,b} (NOR = 4'b0001); latched at start.
- `y_in`  in  1  output of the gate under test.
- `a_out`  out  1  drives gate input `a`.
- `b_out`  out  1  drives gate input `b`.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  1 when the last completed run had no mismatch.
- `fail_mask`  out  4  bit i = 1 when vector i ({a,b}=i) mismatched.
- `err_count`  out  3  number of mismatching vectors (0–4).

## Operation
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - On `start`: latch `tt_expected`, clear `fail_mask`, `err_count` and `pass`, set idx=0, drive {a_out,b_out}=2'b00, set cnt=0, go to SETTLE.
  - Without `start`, hold all outputs.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - Compare `y_in` against latched bit [idx].
  - A value other than a clean 0/1 (x/z, compared with case equality) counts as a mismatch.
  - On mismatch, set fail_mask[idx] and increment err_count.
  - If idx==3, go to DONE. Otherwise idx++, drive the next vector (order 00, 01, 10, 11), set cnt=0, go to SETTLE.
- DONE:
  - Assert `done` for one cycle.
  - Set pass = (err_count==0), using the final value including the last sample.
  - Go to IDLE.
- Results (`pass`, `fail_mask`, `err_count`) hold until the next accepted `start`.
- `start` outside IDLE is ignored; it is not queued.
- `abort` in SETTLE or SAMPLE:
  - Next state is IDLE, with a_out=b_out=0 and pass=0.
  - No `done` pulse.
  - fail_mask and err_count keep their partial values.
  - `abort` takes priority over the SAMPLE update in the same cycle.
- `start` and `abort` together in IDLE: `start` wins.

## Timing
- Reset values: state=IDLE; a_out=b_out=0; busy=0; done=0; pass=0; fail_mask=0; err_count=0; idx=0; cnt=0.
- Reset asserted mid-run returns to these values on the next edge, with no `done` pulse.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES settling cycles plus 1 sample cycle.
- `start` accepted at edge k:
  - vector 0 is visible after edge k;
  - `done` is high in the cycle after edge k+4·(SETTLE_CYCLES+1).
  - With SETTLE_CYCLES=2, `done` goes high 12 edges after start.
- `a_out`/`b_out` change only on the edge that enters SETTLE; they are stable throughout SETTLE and SAMPLE.
- `y_in` is sampled at the edge that leaves SAMPLE. It is not registered beforehand, so there is no extra latency.
- `busy` and `done` are registered outputs decoded from the state.
- `err_count` saturates naturally at 4; it never wraps.

## Structure
- Shared package `gate_test_pkg` holds:
  - the state enum;
  - the vector order constant;
  - truth-table constants TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- One natural sub-module, `gate_settle_timer`:
  - a load/count-down counter with `load` and `expired` signals;
  - width $clog2(SETTLE_CYCLES+1).
- The FSM, idx and result registers stay in the top module.

## Test plan
- NOR cell attached, tt_expected=TT_NOR, SETTLE_CYCLES=2, pulse start → `done` 12 edges after start; pass=1, fail_mask=0, err_count=0.
- NOR cell attached, tt_expected=TT_NAND → pass=0, fail_mask=4'b0110, err_count=2.
- y_in tied to 1'bz → fail_mask=4'b1111, err_count=4, pass=0.
- start re-pulsed while busy, then abort during the vector-2 SETTLE → no `done`; a_out=b_out=0 and state=IDLE next cycle; fail_mask reflects only vectors 0–1.
- rst_n low for one cycle during SAMPLE of vector 3 → all outputs at reset values on the next edge; a fresh start then completes normally.
- SETTLE_CYCLES=1, back-to-back runs with start asserted in the cycle after `done` → second run accepted, results cleared, `done` again after 8 edges.
